neuron_layer_ctrl: RTL

Sequencer that evaluates one fully-connected layer of N two-input neurons by time-multiplexing a single combinational `neuron` datapath. It has three parts:
- a register file of per-neuron bias and weights, loaded through a config port;
- a valid/ready input port that accepts one (x1, x2) sample;
- a valid/ready output port that returns the N activations in index order.

All values are signed Q16.16 (1.0 = 65536).

---
 rtl/neuron_layer_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/neuron_layer_ctrl.sv
// Sequencer for one fully-connected layer of two-input neurons.
// A single combinational neuron is time-multiplexed over all indices.
module neuron_layer_ctrl #(
    parameter int N_NEURONS = 4,
    parameter int IDXW      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [IDXW-1:0]        cfg_idx,
    input  logic [1:0]             cfg_sel,
    input  logic signed [31:0]     cfg_wdata,
    output logic                   cfg_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [31:0]     in_x1,
    input  logic signed [31:0]     in_x2,
    output logic signed [31:0]     n_b,
    output logic signed [31:0]     n_x1,
    output logic signed [31:0]     n_w1,
    output logic signed [31:0]     n_x2,
    output logic signed [31:0]     n_w2,
    input  logic signed [31:0]     n_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [31:0]     out_data,
    output logic [IDXW-1:0]        out_idx,
    output logic                   out_last,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_OUT
    } state_t;

    localparam logic [IDXW:0]   LP_NUM  = (IDXW+1)'(N_NEURONS);
    localparam logic [IDXW-1:0] LP_LAST = IDXW'(N_NEURONS - 1);

    state_t r_state;
    state_t w_next;

    logic signed [31:0] r_bias [N_NEURONS];
    logic signed [31:0] r_w1   [N_NEURONS];
    logic signed [31:0] r_w2   [N_NEURONS];

    logic signed [31:0] r_x1;
    logic signed [31:0] r_x2;
    logic [IDXW-1:0]    r_idx;
    logic signed [31:0] r_out_data;
    logic [IDXW-1:0]    r_out_idx;
    logic               r_out_last;
    logic               r_out_valid;
    logic               r_cfg_err;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_cfg_ok;
    logic [IDXW-1:0]    w_op_idx;

    assign w_in_ready = (r_state == S_IDLE) && !cfg_we;
    assign w_accept   = in_valid && w_in_ready;
    assign w_cfg_ok   = cfg_we && (r_state == S_IDLE) &&
                        (cfg_sel != 2'd3) &&
                        ({1'b0, cfg_idx} < LP_NUM);

    // Idle presents neuron 0 so the operand bus is never stale.
    assign w_op_idx = (r_state == S_IDLE) ? '0 : r_idx;

    assign n_b  = r_bias[w_op_idx];
    assign n_w1 = r_w1[w_op_idx];
    assign n_w2 = r_w2[w_op_idx];
    assign n_x1 = r_x1;
    assign n_x2 = r_x2;

    assign in_ready  = w_in_ready;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign cfg_err   = r_cfg_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    w_next = r_out_last ? S_IDLE : S_DRIVE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_bias[i] <= '0;
                r_w1[i]   <= '0;
                r_w2[i]   <= '0;
            end
        end else if (w_cfg_ok) begin
            case (cfg_sel)
                2'd0:    r_bias[cfg_idx] <= cfg_wdata;
                2'd1:    r_w1[cfg_idx]   <= cfg_wdata;
                2'd2:    r_w2[cfg_idx]   <= cfg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x1        <= '0;
            r_x2        <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x1  <= in_x1;
                        r_x2  <= in_x2;
                        r_idx <= '0;
                    end
                end
                S_DRIVE: begin
                    r_out_data  <= n_out;
                    r_out_idx   <= r_idx;
                    r_out_last  <= (r_idx == LP_LAST);
                    r_out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (!r_out_last) begin
                            r_idx <= r_idx + IDXW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
